// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and default widths for the pipe_stage_skid slice.
// Optional feature: PIPE_STAGE_PERF_EN enables the stall/flush counters.
package pipe_pkg;

  // Default payload and performance counter widths.
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 32;

  // Occupancy of the stage: nothing held, main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_perf_ctr.sv
// pipe_perf_ctr: saturating event counter. It counts by one on every enabled
// cycle, sticks at all-ones and clears only on reset.
module pipe_perf_ctr
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic at_max;

  // Saturation detect kept separate so the increment never wraps.
  always_comb begin
    at_max = (count == CNT_MAX);
  end

  // Counter register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + CNT_ONE;
    end
  end

endmodule : pipe_perf_ctr

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one-deep valid/ready pipeline stage with a skid register so
// in_ready and out_valid come straight from flops (no combinational path from
// the input handshake to the output handshake).
// Optional feature: define PIPE_STAGE_PERF_EN to build the stall/flush
// counters; without it the counter ports are tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | nothing held; in_ready=1, out_valid=0
// FULL  | main holds the oldest entry; in_ready=1, out_valid=1
// SKID  | main holds the oldest, skid the next; in_ready=0, out_valid=1
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e state;
  pipe_state_e state_nxt;

  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  // Handshake transfers; both readies/valids are decoded from state flops.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
  end

  // State register; reset outranks flush, flush outranks every transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from occupancy and the two transfers.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nxt = FULL;
        end
        FULL: begin
          if (in_fire && !out_fire)      state_nxt = SKID;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        SKID: begin
          if (out_fire) state_nxt = FULL;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs and datapath load strobes decoded from the state.
  always_comb begin
    in_ready       = (state != SKID);
    out_valid      = (state != EMPTY);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: load_main_in = in_fire;
      FULL: begin
        load_main_in = in_fire & out_fire;
        load_skid    = in_fire & ~out_fire;
      end
      SKID: load_main_skid = out_fire;
      default: ;
    endcase
  end

  // Payload registers; an entry accepted during a flush is simply dropped.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = main_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt;

  // A stall is a cycle where an entry is offered but not taken.
  always_comb begin
    stall_evt = out_valid & ~out_ready;
  end

  pipe_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk    (clk),
    .resetn (resetn),
    .en     (stall_evt),
    .count  (stall_cnt)
  );

  pipe_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .clk    (clk),
    .resetn (resetn),
    .en     (flush),
    .count  (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus a randomized run, all checked
// against a queue-based model of a two-entry in-order stage.
module tb_pipe_stage_skid;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] FVAL   = 32'h0BAD_F00D;
  localparam int          CMAX   = 15;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .FLUSH_VAL (FVAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two accepted entries. out_data shows the oldest
  // entry, or the last entry that left if the stage is empty.
  logic [31:0] mq[$];
  logic [31:0] last_m;
  int          stall_m;
  int          flush_m;
  bit          m_ov;
  bit          m_if;

  initial begin
    last_m  = FVAL;
    stall_m = 0;
    flush_m = 0;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      last_m  = FVAL;
      stall_m = 0;
      flush_m = 0;
    end else begin
      m_ov = (mq.size() > 0);
      m_if = in_valid && (mq.size() < 2);
      if (PERF) begin
        if (m_ov && !out_ready && stall_m < CMAX) stall_m++;
        if (flush && flush_m < CMAX) flush_m++;
      end
      if (flush) begin
        mq.delete();
        last_m = FVAL;
      end else begin
        if (m_ov && out_ready) last_m = mq.pop_front();
        if (m_if) mq.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : last_m);
      chk("stall_cnt", {28'd0, stall_cnt}, stall_m);
      chk("flush_cnt", {28'd0, flush_cnt}, flush_m);
    end
  end

  initial begin
    resetn = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, FVAL);
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);

    // First transfer: one-cycle latency.
    resetn = 1; in_valid = 1; in_data = 32'h13; out_ready = 1;
    @(negedge clk);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_data", out_data, 32'h13);
    chk("first_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream at full rate.
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      @(negedge clk);
      chk("stream_data", out_data, i);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 0;
    @(negedge clk);

    // Fill the skid register, then release the downstream.
    in_valid = 1; in_data = 32'hA;
    @(negedge clk);
    chk("skid_a", out_data, 32'hA);
    in_data = 32'hB; out_ready = 0;
    @(negedge clk);
    in_data = 32'hC;
    repeat (2) begin
      chk("skid_ready", {31'd0, in_ready}, 32'd0);
      chk("skid_hold", out_data, 32'hA);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("drain_b", out_data, 32'hB);
    chk("drain_b_v", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("drain_c", out_data, 32'hC);
    chk("drain_c_v", {31'd0, out_valid}, 32'd1);
    in_valid = 0;
    @(negedge clk);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush from SKID with an offered entry that must never appear.
    resetn = 0;
    @(negedge clk);
    resetn = 1; in_valid = 1; in_data = 32'hA; out_ready = 0;
    @(negedge clk);
    in_data = 32'hB;
    @(negedge clk);
    chk("pre_flush_skid", {31'd0, in_ready}, 32'd0);
    flush = 1; in_data = 32'hDEAD;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", out_data, FVAL);
    chk("flush_cnt1", {28'd0, flush_cnt}, PERF ? 32'd1 : 32'd0);
    // Flush in a cycle where the entry is accepted: it is dropped.
    @(negedge clk);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_drop", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt2", {28'd0, flush_cnt}, PERF ? 32'd2 : 32'd0);

    // Reset and flush on the same edge while FULL.
    in_valid = 1; in_data = 32'h55; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    flush = 1; resetn = 0;
    @(negedge clk);
    chk("rf_stall", {28'd0, stall_cnt}, 32'd0);
    chk("rf_flush", {28'd0, flush_cnt}, 32'd0);
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    chk("rf_ready", {31'd0, in_ready}, 32'd1);
    flush = 0; resetn = 1;

    // Stall counter saturation.
    in_valid = 1; in_data = 32'h77;
    @(negedge clk);
    in_valid = 0;
    repeat (20) @(negedge clk);
    chk("stall_sat", {28'd0, stall_cnt}, PERF ? 32'd15 : 32'd0);
    chk("stall_hold", out_data, 32'h77);
    out_ready = 1;
    @(negedge clk);

    // Randomized traffic with varying backpressure, flushes and resets.
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = 20 + 15 * blk;
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 99) < 70);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        flush     = ($urandom_range(0, 49) == 0);
        resetn    = ($urandom_range(0, 299) != 0);
        @(negedge clk);
      end
    end
    resetn = 1; flush = 0; in_valid = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, payload width in bits (min 1).
REQ-002 The block SHALL have parameter FLUSH_VAL, default '0 (DATA_W bits), value loaded into payload registers on reset or flush.
REQ-003 The block SHALL have parameter CNT_W, default 32, performance counter width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port resetn, input, 1: synchronous, active-low reset.
REQ-006 Port flush, input, 1: discard all held entries this cycle.
REQ-007 Port in_valid, input, 1: upstream entry present.
REQ-008 Port in_ready, output, 1: stage can accept an entry.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: downstream entry present.
REQ-011 Port out_ready, input, 1: downstream accepts.
REQ-012 Port out_data, output, DATA_W: downstream payload.
REQ-013 Port stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.
REQ-014 Port flush_cnt, output, CNT_W: cycles with flush=1.

Function
REQ-015 The stage SHALL hold a main register (drives out_data) and one skid register; states EMPTY, FULL, SKID.
REQ-016 in_fire = in_valid & in_ready and out_fire = out_valid & out_ready SHALL define transfers.
REQ-017 in_ready SHALL equal (state != SKID) and out_valid SHALL equal (state != EMPTY), both decoded from registers only (no in-to-out combinational path).
REQ-018 EMPTY: in_fire SHALL load main, next FULL; otherwise stay EMPTY.
REQ-019 FULL: in_fire & out_fire SHALL load main, stay FULL; in_fire & !out_fire SHALL load skid, go SKID; !in_fire & out_fire SHALL go EMPTY; neither SHALL hold.
REQ-020 SKID: out_fire SHALL move skid to main, go FULL; otherwise hold both.
REQ-021 Latency in_fire to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 entry/cycle with out_ready=1.
REQ-022 Entries SHALL leave in acceptance order; none lost or duplicated.
REQ-023 flush=1 SHALL override all transitions: next state EMPTY, main and skid loaded with FLUSH_VAL; an in_fire in the flush cycle SHALL complete the handshake and its data SHALL be dropped.
REQ-024 Registers not written in a cycle SHALL hold their value; out_data SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-025 resetn=0 at a clock edge SHALL set state EMPTY, main and skid to FLUSH_VAL, stall_cnt and flush_cnt to 0, with priority over flush and handshakes.
REQ-026 After reset: in_ready=1, out_valid=0, out_data=FLUSH_VAL; reset mid-transfer SHALL discard all held entries.

Configuration
REQ-027 Macro PIPE_STAGE_PERF_EN defined: stall_cnt and flush_cnt SHALL increment by 1 on each qualifying cycle, saturating at 2^CNT_W-1; flush SHALL not clear them.
REQ-028 Macro PIPE_STAGE_PERF_EN undefined: ports SHALL remain present, tied to 0, no counter flops.

Structure
REQ-029 Package pipe_pkg SHALL hold enum pipe_state_e {EMPTY, FULL, SKID} and default DATA_W/CNT_W constants.
REQ-030 Sub-module pipe_perf_ctr (saturating enable counter, CNT_W) SHALL be instanced twice, only under PIPE_STAGE_PERF_EN.

Verification
REQ-031 Reset, then in_valid=1, in_data=0x00000013, out_ready=1 -> next cycle out_valid=1, out_data=0x00000013, in_ready=1.
REQ-032 Stream 0x1..0x8, out_ready=1 throughout -> out_data 0x1..0x8 on 8 consecutive cycles, in_ready never 0.
REQ-033 Stream 0xA,0xB,0xC with out_ready=0 from cycle 1 -> state SKID, in_ready=0, 0xC held upstream; out_ready=1 -> outputs 0xA,0xB,0xC in order, no gap.
REQ-034 SKID state, flush=1 with in_valid=1 in_data=0xDEAD -> next cycle out_valid=0, out_data=FLUSH_VAL, 0xDEAD never output, flush_cnt=1 (macro on).
REQ-035 flush=1 and resetn=0 same edge while FULL -> counters 0, state EMPTY.
REQ-036 Macro on, CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated); macro off -> stall_cnt=0.
